// File: rtl/prog_counter_if.sv
// prog_counter_if -- control/status bundle for prog_counter.
//   master : drives en, clr, load, load_val, dir, mode, limit, prescale,
//            cmp_val; observes count, tc, cmp_match, done, running.
//   slave  : the counter itself (mirror directions).
interface prog_counter_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
);
  logic                  en;
  logic                  clr;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic                  dir;
  logic [1:0]            mode;
  logic [WIDTH-1:0]      limit;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      cmp_val;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  cmp_match;
  logic                  done;
  logic                  running;

  modport master (
    output en, clr, load, load_val, dir, mode, limit, prescale, cmp_val,
    input  count, tc, cmp_match, done, running
  );

  modport slave (
    input  en, clr, load, load_val, dir, mode, limit, prescale, cmp_val,
    output count, tc, cmp_match, done, running
  );
endinterface

// File: rtl/prog_counter.sv
// prog_counter -- prescaled up/down counter with wrap, saturate and
// one-shot terminal behaviour.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : prog_counter_if.slave
//     en/clr/load/load_val : enable, sync clear, sync load (clr > load > tick)
//     dir (1=up), mode (00 wrap, 01 saturate, 10 one-shot, 11 wrap)
//     limit    : count range is [0, limit]
//     prescale : one tick per prescale+1 enabled cycles
//     cmp_val  : compare value for cmp_match
//     count, tc (registered terminal pulse), done (one-shot complete),
//     cmp_match = (count == cmp_val), running = en && !done
module prog_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  prog_counter_if.slave bus
);

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] pc_q, pc_d;
  logic                  tc_q, tc_d;
  logic                  done_q, done_d;
  logic                  tick;
  logic                  terminal;

  always_comb begin
    tick     = bus.en && (pc_q == bus.prescale);
    terminal = bus.dir ? (count_q >= bus.limit) : (count_q == '0);
  end

  always_comb begin
    count_d = count_q;
    pc_d    = pc_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    if (bus.clr) begin
      count_d = '0;
      pc_d    = '0;
      done_d  = 1'b0;
    end else if (bus.load) begin
      count_d = bus.load_val;
      pc_d    = '0;
      done_d  = 1'b0;
    end else begin
      if (bus.en) begin
        pc_d = tick ? '0 : pc_q + PRESCALE_W'(1);
      end
      // A completed one-shot freezes count and tc; the prescaler keeps running.
      if (tick && !done_q) begin
        if (!terminal) begin
          count_d = bus.dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end else begin
          tc_d = 1'b1;
          case (bus.mode)
            MODE_SAT:     count_d = count_q;
            MODE_ONESHOT: done_d  = 1'b1;
            MODE_WRAP:    count_d = bus.dir ? '0 : bus.limit;
            default:      count_d = bus.dir ? '0 : bus.limit;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      pc_q    <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.tc        = tc_q;
  assign bus.done      = done_q;
  assign bus.cmp_match = (count_q == bus.cmp_val);
  assign bus.running   = bus.en && !done_q;

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the count register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter PRESCALE_W, default 4, giving the prescaler compare width in bits (legal range 1..16).
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port en, input, 1 bit: count enable; feeds the prescaler.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous load of load_val.
REQ-008 The block SHALL have port load_val, input, WIDTH bits: value written to count on load.
REQ-009 The block SHALL have port dir, input, 1 bit: direction; 1 = up, 0 = down.
REQ-010 The block SHALL have port mode, input, 2 bits: 00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved and treated as wrap.
REQ-011 The block SHALL have port limit, input, WIDTH bits: upper bound of the count range [0, limit].
REQ-012 The block SHALL have port prescale, input, PRESCALE_W bits: one tick per prescale+1 enabled cycles.
REQ-013 The block SHALL have port cmp_val, input, WIDTH bits: compare value.
REQ-014 The block SHALL have port count, output, WIDTH bits: current registered count.
REQ-015 The block SHALL have port tc, output, 1 bit: registered terminal-count pulse.
REQ-016 The block SHALL have port cmp_match, output, 1 bit: combinational flag, count == cmp_val.
REQ-017 The block SHALL have port done, output, 1 bit: registered one-shot-complete flag.
REQ-018 The block SHALL have port running, output, 1 bit: combinational flag, en && !done.

Function
REQ-019 Internal prescaler pc (PRESCALE_W bits) SHALL increment on each clock with en=1 and no clr/load; when pc == prescale, the cycle SHALL be a tick and pc SHALL return to 0; en=0 SHALL hold pc.
REQ-020 Priority per edge SHALL be clr > load > tick; clr SHALL set count=0, pc=0, done=0; load SHALL set count=load_val, pc=0, done=0.
REQ-021 tc SHALL be 0 on every edge except a terminal tick, where it SHALL be 1 for exactly the following cycle; clr or load on that edge SHALL force tc=0.
REQ-022 Terminal tick: a tick with dir=1 and count >= limit, or dir=0 and count == 0.
REQ-023 Non-terminal tick: count SHALL become count+1 (up) or count-1 (down), modulo 2^WIDTH; a down tick with count > limit SHALL decrement normally.
REQ-024 Wrap mode terminal tick: up SHALL load 0, down SHALL load limit; tc pulses.
REQ-025 Saturate mode terminal tick: count SHALL hold; tc SHALL pulse on every such tick.
REQ-026 One-shot mode terminal tick: count SHALL hold, done SHALL be set, tc pulses; while done=1, ticks SHALL NOT change count and SHALL NOT pulse tc (pc still advances).
REQ-027 done SHALL clear only on clr, load or reset; a mode change SHALL NOT clear done.
REQ-028 Changes to limit, prescale, dir or mode SHALL take effect on the next edge with no pipeline delay.
REQ-029 limit = 0 SHALL make every tick terminal; prescale = 0 SHALL make every enabled cycle a tick.

Reset
REQ-030 rst_n low SHALL immediately set count=0, pc=0, tc=0, done=0, independent of clk.
REQ-031 On reset release, the first edge with rst_n high SHALL act as a normal cycle.
REQ-032 Reset asserted mid-operation SHALL abort any count, pulse or one-shot immediately.

Verification
REQ-033 Wrap up: WIDTH=8, prescale=0, limit=9, dir=1, mode=00, en=1 after reset -> count 0..9,0,1; tc=1 only in the cycle count returns to 0.
REQ-034 Saturate down: limit=5, load 2, then dir=0, mode=01 -> count 2,1,0,0,0; tc=1 in each cycle after a tick taken at 0.
REQ-035 Prescale: prescale=3, up wrap -> count advances every 4th enabled cycle; en low for 2 cycles mid-period -> that advance is delayed by exactly 2 cycles.
REQ-036 One-shot: limit=3, up, mode=10 -> 0,1,2,3,3; done=1 and one tc pulse; running=0; load_val=1 with load -> count=1, done=0.
REQ-037 Simultaneous events: clr+load+tick on one edge -> count=0, tc=0; load on a terminal tick -> count=load_val, tc=0.
REQ-038 Async reset: rst_n low mid-count (count=7, done=1) between edges -> count=0, done=0, tc=0 before the next clk edge; cmp_val=0 -> cmp_match=1.
